// File: rtl/sync_filter_pkg.sv
// Shared constants, legal parameter ranges and helpers for the multi-channel
// input synchroniser / debounce filter bank.
package sync_filter_pkg;

  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_SYNC_FF    = 2;
  localparam int DEF_FILTER_LEN = 4;
  localparam int DEF_CNT_W      = 8;

  localparam int MIN_CHANNELS   = 1;
  localparam int MAX_CHANNELS   = 32;
  localparam int MIN_SYNC_FF    = 2;
  localparam int MAX_SYNC_FF    = 4;
  localparam int MIN_FILTER_LEN = 1;
  localparam int MAX_FILTER_LEN = 255;
  localparam int MIN_CNT_W      = 1;
  localparam int MAX_CNT_W      = 16;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Stability counter must be able to hold FILTER_LEN-1 (and stays >= 1 bit).
  function automatic int fc_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: synchroniser chain, stability filter, edge pulses and a
// saturating event counter.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int   SYNC_FF    = DEF_SYNC_FF,
  parameter int   FILTER_LEN = DEF_FILTER_LEN,
  parameter int   CNT_W      = DEF_CNT_W,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             async_in,
  input  logic             cnt_clr,
  output logic             level_out,
  output logic             rise_out,
  output logic             fall_out,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int               FC_W    = fc_width(FILTER_LEN);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_FF-1:0] r_sync;
  logic [FC_W-1:0]  r_fc;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic  w_syn;
  logic  w_differ;
  logic  w_commit;
  edge_e w_edge;

  // Plain shift chain: nothing may sit between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {SYNC_FF{RST_VAL}};
    else     r_sync <= {r_sync[SYNC_FF-2:0], async_in};
  end

  assign w_syn    = r_sync[SYNC_FF-1];
  assign w_differ = (w_syn != r_level);
  assign w_commit = w_differ && (r_fc == FC_LAST);

  always_comb begin
    w_edge = EDGE_NONE;
    if (w_commit) w_edge = w_syn ? EDGE_RISE : EDGE_FALL;
  end

  // Any return to the committed level before FILTER_LEN samples drops the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fc    <= '0;
      r_level <= RST_VAL;
    end else begin
      if (!w_differ || w_commit) r_fc <= '0;
      else                       r_fc <= r_fc + FC_W'(1);
      if (w_commit) r_level <= w_syn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= (w_edge == EDGE_RISE);
      r_fall <= (w_edge == EDGE_FALL);
    end
  end

  // A clear coinciding with a commit keeps that commit as the first new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_commit) begin
      if (cnt_clr)               r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end
  end

  assign level_out = r_level;
  assign rise_out  = r_rise;
  assign fall_out  = r_fall;
  assign evt_cnt   = r_cnt;

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of independent input conditioners bringing CHANNELS asynchronous bits
// into the clk domain; counters are packed channel-major into evt_cnt.
module sync_filter_bank
  import sync_filter_pkg::*;
#(
  parameter int                  CHANNELS   = DEF_CHANNELS,
  parameter int                  SYNC_FF    = DEF_SYNC_FF,
  parameter int                  FILTER_LEN = DEF_FILTER_LEN,
  parameter int                  CNT_W      = DEF_CNT_W,
  parameter logic [CHANNELS-1:0] RESET_VAL  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       async_in,
  input  logic [CHANNELS-1:0]       cnt_clr,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       rise_out,
  output logic [CHANNELS-1:0]       fall_out,
  output logic [CHANNELS*CNT_W-1:0] evt_cnt
);

  if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("sync_filter_bank: CHANNELS out of range");
  end
  if (SYNC_FF < MIN_SYNC_FF || SYNC_FF > MAX_SYNC_FF) begin : g_bad_sync_ff
    $error("sync_filter_bank: SYNC_FF out of range");
  end
  if (FILTER_LEN < MIN_FILTER_LEN || FILTER_LEN > MAX_FILTER_LEN) begin : g_bad_filter_len
    $error("sync_filter_bank: FILTER_LEN out of range");
  end
  if (CNT_W < MIN_CNT_W || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
    $error("sync_filter_bank: CNT_W out of range");
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    sync_filter_ch #(
      .SYNC_FF    (SYNC_FF),
      .FILTER_LEN (FILTER_LEN),
      .CNT_W      (CNT_W),
      .RST_VAL    (RESET_VAL[gi])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .async_in  (async_in[gi]),
      .cnt_clr   (cnt_clr[gi]),
      .level_out (level_out[gi]),
      .rise_out  (rise_out[gi]),
      .fall_out  (fall_out[gi]),
      .evt_cnt   (evt_cnt[gi*CNT_W +: CNT_W])
    );
  end

endmodule
